// File: rtl/trena_sequenciador_uc.sv
// Control unit for the digital tape-measure family. It requests one measurement,
// then walks the datapath character mux through every field, sending NUM_DIGITOS
// digits (most significant first) and a terminator per field. It also handles the
// measurement timeout, continuous mode and aborts when ligar is dropped.
module trena_sequenciador_uc #(
    parameter int unsigned NUM_CAMPOS     = 2,
    parameter int unsigned NUM_DIGITOS    = 3,
    parameter int unsigned TIMEOUT_CICLOS = 50000000,
    parameter int unsigned CW             = (NUM_CAMPOS > 1) ? $clog2(NUM_CAMPOS) : 1,
    parameter int unsigned DW             = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ligar,
    input  logic          mensurar,
    input  logic          modo_continuo,
    input  logic          medida_pronto,
    input  logic          envio_pronto,
    output logic          medir,
    output logic          transmitir,
    output logic [CW-1:0] sel_campo,
    output logic [DW-1:0] sel_digito,
    output logic          envia_final,
    output logic          pronto,
    output logic          timeout,
    output logic [3:0]    db_estado
);

    localparam int unsigned TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TW-1:0] CntMax =
        TW'((TIMEOUT_CICLOS == 0) ? 0 : TIMEOUT_CICLOS - 1);
    localparam logic [CW-1:0] UltimoCampo = CW'(NUM_CAMPOS - 1);
    localparam logic [DW-1:0] DigitoMsd   = DW'(NUM_DIGITOS - 1);

    // Enumerator values double as the debug display codes.
    typedef enum logic [3:0] {
        Inicial           = 4'h0,
        FazMedida         = 4'h1,
        AguardaMedida     = 4'h2,
        Transmite         = 4'h3,
        EsperaTransmissao = 4'h4,
        Erro              = 4'hE,
        Fim               = 4'hF
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [CW-1:0]   campo_q, campo_d;
    logic [DW-1:0]   digito_q, digito_d;
    logic            final_q, final_d;
    logic [TW-1:0]   cnt_q, cnt_d;

    // State, character counters and timeout counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= Inicial;
            campo_q  <= '0;
            digito_q <= DigitoMsd;
            final_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            campo_q  <= campo_d;
            digito_q <= digito_d;
            final_q  <= final_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state, counter updates and Moore pulse outputs.
    always_comb begin
        estado_d   = estado_q;
        campo_d    = campo_q;
        digito_d   = digito_q;
        final_d    = final_q;
        cnt_d      = cnt_q;
        medir      = 1'b0;
        transmitir = 1'b0;
        pronto     = 1'b0;
        timeout    = 1'b0;

        case (estado_q)
            Inicial: begin
                if (ligar && mensurar) estado_d = FazMedida;
            end
            FazMedida: begin
                medir    = 1'b1;
                cnt_d    = '0;
                estado_d = ligar ? AguardaMedida : Inicial;
            end
            AguardaMedida: begin
                cnt_d = cnt_q + 1'b1;
                if (!ligar) begin
                    estado_d = Inicial;
                end else if (medida_pronto) begin
                    estado_d = Transmite;
                end else if ((TIMEOUT_CICLOS != 0) && (cnt_q == CntMax)) begin
                    estado_d = Erro;
                end
            end
            Transmite: begin
                transmitir = 1'b1;
                estado_d   = ligar ? EsperaTransmissao : Inicial;
            end
            EsperaTransmissao: begin
                // A character already on the line is always allowed to finish.
                if (envio_pronto) begin
                    if (!ligar) begin
                        estado_d = Inicial;
                    end else if (final_q && (campo_q == UltimoCampo)) begin
                        estado_d = Fim;
                    end else begin
                        estado_d = Transmite;
                        if (final_q) begin
                            campo_d  = campo_q + 1'b1;
                            digito_d = DigitoMsd;
                            final_d  = 1'b0;
                        end else if (digito_q == '0) begin
                            final_d = 1'b1;
                        end else begin
                            digito_d = digito_q - 1'b1;
                        end
                    end
                end
            end
            Erro: begin
                timeout  = 1'b1;
                estado_d = Inicial;
            end
            Fim: begin
                pronto   = 1'b1;
                estado_d = (ligar && modo_continuo) ? FazMedida : Inicial;
            end
            default: estado_d = Inicial;
        endcase

        // Every new measurement starts from the first field's most significant digit.
        if ((estado_d == Inicial) || (estado_d == FazMedida)) begin
            campo_d  = '0;
            digito_d = DigitoMsd;
            final_d  = 1'b0;
        end
    end

    assign sel_campo   = campo_q;
    assign sel_digito  = digito_q;
    assign envia_final = final_q;

    // Debug code: legal states show their own code, anything else shows D.
    always_comb begin
        db_estado = 4'hD;
        case (estado_q)
            Inicial, FazMedida, AguardaMedida, Transmite, EsperaTransmissao, Erro, Fim:
                db_estado = estado_q;
            default: db_estado = 4'hD;
        endcase
    end

endmodule
